// File: rtl/mac_stream_driver_if.sv
// Signal bundle between the MAC stream driver, its upstream/downstream streams and the MAC.
// The master modport is the driver's view; slave is the view of everything around it.
interface mac_stream_driver_if #(
    parameter int AW = 14,
    parameter int FW = 28,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_a;
    logic [AW-1:0] in_b;

    logic          mac_reset;
    logic [AW-1:0] mac_a;
    logic [AW-1:0] mac_b;
    logic          mac_valid_in;
    logic [FW-1:0] mac_f;
    logic          mac_valid_out;

    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_data;
    logic [CW-1:0] out_count;

    modport master (
        input  in_valid, in_a, in_b, mac_f, mac_valid_out, out_ready,
        output in_ready, mac_reset, mac_a, mac_b, mac_valid_in,
               out_valid, out_data, out_count
    );

    modport slave (
        output in_valid, in_a, in_b, mac_f, mac_valid_out, out_ready,
        input  in_ready, mac_reset, mac_a, mac_b, mac_valid_in,
               out_valid, out_data, out_count
    );
endinterface

// File: rtl/mac_stream_driver.sv
// Feeds N operand pairs into the 14x14 signed MAC, waits for its N responses,
// hands the dot product downstream and clears the MAC before the next vector.
module mac_stream_driver #(
    parameter int N  = 4,
    parameter int AW = 14,
    parameter int FW = 28,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    mac_stream_driver_if.master bus
);
    typedef enum logic [1:0] {CLEAR, STREAM, DRAIN, HOLD} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t        state_reg;
    logic [CW-1:0] issue_cnt_reg;
    logic [CW-1:0] resp_cnt_reg;
    logic [CW-1:0] out_count_reg;
    logic [FW-1:0] out_data_reg;
    logic          out_valid_reg;

    logic          in_ready;
    logic          accept;
    logic          last_resp;
    logic [AW-1:0] mac_a_gated;
    logic [AW-1:0] mac_b_gated;

    assign in_ready  = (state_reg == STREAM);
    assign accept    = bus.in_valid & in_ready;
    assign last_resp = bus.mac_valid_out & (resp_cnt_reg == LAST_IDX);

    // Operands are forced to zero whenever no pair is handed to the MAC.
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_operand_gate
            assign mac_a_gated[gi] = bus.in_a[gi] & accept;
            assign mac_b_gated[gi] = bus.in_b[gi] & accept;
        end
    endgenerate

    assign bus.in_ready     = in_ready;
    assign bus.mac_valid_in = accept;
    assign bus.mac_a        = mac_a_gated;
    assign bus.mac_b        = mac_b_gated;
    assign bus.mac_reset    = reset | (state_reg == CLEAR);
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_count    = out_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= CLEAR;
            issue_cnt_reg <= '0;
            resp_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    issue_cnt_reg <= '0;
                    resp_cnt_reg  <= '0;
                    state_reg     <= STREAM;
                end
                STREAM: begin
                    if (accept) begin
                        issue_cnt_reg <= issue_cnt_reg + CW'(1);
                        if (issue_cnt_reg == LAST_IDX) begin
                            state_reg <= DRAIN;
                        end
                    end
                    // Early responses arrive while later pairs are still streaming in.
                    if (bus.mac_valid_out) begin
                        resp_cnt_reg <= resp_cnt_reg + CW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.mac_valid_out) begin
                        resp_cnt_reg <= resp_cnt_reg + CW'(1);
                    end
                    if (last_resp) begin
                        out_data_reg  <= bus.mac_f;
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_count_reg <= out_count_reg + CW'(1);
                        state_reg     <= CLEAR;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end
endmodule
